// File: rtl/route_lock_demux_pkg.sv
// Shared router types and constants: AXIS stream structs, channel indices,
// header TID, routing-mode and routing-FSM state enums.
package route_lock_demux_pkg;

  // AXIS field widths shared by every port that carries axis_mosi_t.
  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_ID_WIDTH   = 4;
  localparam int AXIS_DEST_WIDTH = 4;
  localparam int AXIS_USER_WIDTH = 4;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_ID_WIDTH-1:0]   tid;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
    logic [AXIS_USER_WIDTH-1:0] tuser;
    logic                       tlast;
  } axis_data_t;

  typedef struct packed {
    logic       tvalid;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  // Channel indices are carried in 3 bits, so a router has at most 8 ports.
  localparam int MAX_CHANNELS = 8;
  typedef logic [2:0] chan_idx_t;

  localparam chan_idx_t CH_LOCAL = 3'd0;
  localparam chan_idx_t CH_NORTH = 3'd1;  // y + 1
  localparam chan_idx_t CH_EAST  = 3'd2;  // x + 1
  localparam chan_idx_t CH_SOUTH = 3'd3;  // y - 1
  localparam chan_idx_t CH_WEST  = 3'd4;  // x - 1

  // TID value that marks the first (routing) beat of a packet.
  localparam logic [AXIS_ID_WIDTH-1:0] ROUTING_HEADER = 4'hF;

  typedef enum logic {
    ROUTE_XY = 1'b0,  // resolve X first
    ROUTE_YX = 1'b1   // resolve Y first
  } routing_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Width of a mesh coordinate; a one-wide mesh still gets a 1-bit port.
  function automatic int coord_width(input int routers);
    return (routers > 1) ? $clog2(routers) : 1;
  endfunction

endpackage

// File: rtl/route_lock_demux_route_compute.sv
// Dimension-order route computation: maps a header's target coordinates to
// an output channel and flags targets that cannot be routed from here.
module route_compute
  import route_lock_demux_pkg::*;
#(
  parameter  int CHANNEL_NUMBER = 5,
  parameter  int MAX_ROUTERS_X  = 4,
  parameter  int MAX_ROUTERS_Y  = 4,
  parameter  int ROUTER_X       = 0,
  parameter  int ROUTER_Y       = 0,
  parameter  int ROUTING_MODE   = 0,
  localparam int XW             = coord_width(MAX_ROUTERS_X),
  localparam int YW             = coord_width(MAX_ROUTERS_Y)
) (
  input  logic [XW-1:0] target_x,
  input  logic [YW-1:0] target_y,
  output chan_idx_t     route,
  output logic          unroutable
);

  routing_mode_e mode;
  logic [31:0]   tx;
  logic [31:0]   ty;
  logic          x_differs;
  logic          y_differs;
  chan_idx_t     x_chan;
  chan_idx_t     y_chan;

  assign mode = (ROUTING_MODE != 0) ? ROUTE_YX : ROUTE_XY;

  // Pick the channel for the first unresolved axis in routing order.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a signal unassigned and no latch is inferred.
    route      = CH_LOCAL;
    unroutable = 1'b0;

    tx        = 32'(target_x);
    ty        = 32'(target_y);
    x_differs = (tx != ROUTER_X);
    y_differs = (ty != ROUTER_Y);
    x_chan    = (tx > ROUTER_X) ? CH_EAST  : CH_WEST;
    y_chan    = (ty > ROUTER_Y) ? CH_NORTH : CH_SOUTH;

    if (mode == ROUTE_XY) begin
      if (x_differs)      route = x_chan;
      else if (y_differs) route = y_chan;
    end else begin
      if (y_differs)      route = y_chan;
      else if (x_differs) route = x_chan;
    end

    // Off-mesh targets, or a direction this router has no port for.
    unroutable = (tx >= MAX_ROUTERS_X) || (ty >= MAX_ROUTERS_Y) ||
                 (32'(route) >= CHANNEL_NUMBER);
  end

endmodule

// File: rtl/route_lock_demux.sv
// Per-input routing stage: steers each packet to one output channel, locks
// that channel from header to TLAST, drops unroutable/malformed packets and
// keeps forwarded/dropped packet statistics. Zero-latency pass-through.
module route_lock_demux
  import route_lock_demux_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ID_WIDTH       = 4,
  parameter  int DEST_WIDTH     = 4,
  parameter  int USER_WIDTH     = 4,
  parameter  int CHANNEL_NUMBER = 5,
  parameter  int MAX_ROUTERS_X  = 4,
  parameter  int MAX_ROUTERS_Y  = 4,
  parameter  int ROUTER_X       = 0,
  parameter  int ROUTER_Y       = 0,
  parameter  int ROUTING_MODE   = 0,
  parameter  int CNT_WIDTH      = 16,
  localparam int XW             = coord_width(MAX_ROUTERS_X),
  localparam int YW             = coord_width(MAX_ROUTERS_Y)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  axis_mosi_t                in_mosi_i,
  output axis_miso_t                in_miso_o,
  output axis_mosi_t                out_mosi_o [CHANNEL_NUMBER],
  input  axis_miso_t                out_miso_i [CHANNEL_NUMBER],
  input  logic [XW-1:0]             target_x_i,
  input  logic [YW-1:0]             target_y_i,
  output logic [CHANNEL_NUMBER-1:0] busy_o,
  output logic                      drop_o,
  output logic [CNT_WIDTH-1:0]      pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]      drop_cnt_o
);

  // The stream structs have fixed field widths; refuse mismatched overrides.
  if (DATA_WIDTH != AXIS_DATA_WIDTH || ID_WIDTH != AXIS_ID_WIDTH ||
      DEST_WIDTH != AXIS_DEST_WIDTH || USER_WIDTH != AXIS_USER_WIDTH ||
      CHANNEL_NUMBER < 1 || CHANNEL_NUMBER > MAX_CHANNELS) begin : g_param_check
    $error("route_lock_demux: unsupported width or channel parameters");
  end

  state_e                    state_q;
  state_e                    state_d;
  chan_idx_t                 lock_q;
  chan_idx_t                 route;
  chan_idx_t                 sel;
  logic                      unroutable;
  logic                      is_header;
  logic                      fwd_en;
  logic                      in_ready;
  logic                      hs;
  logic                      pkt_done;
  logic                      drop_done;
  logic                      route_ready;
  logic                      lock_ready;
  logic [CHANNEL_NUMBER-1:0] ready_vec;
  logic [CHANNEL_NUMBER-1:0] busy_d;

  route_compute #(
    .CHANNEL_NUMBER (CHANNEL_NUMBER),
    .MAX_ROUTERS_X  (MAX_ROUTERS_X),
    .MAX_ROUTERS_Y  (MAX_ROUTERS_Y),
    .ROUTER_X       (ROUTER_X),
    .ROUTER_Y       (ROUTER_Y),
    .ROUTING_MODE   (ROUTING_MODE)
  ) u_route_compute (
    .target_x   (target_x_i),
    .target_y   (target_y_i),
    .route      (route),
    .unroutable (unroutable)
  );

  assign is_header = (in_mosi_i.data.tid == ROUTING_HEADER);

  // Gather per-channel TREADY and pick out the freshly routed and locked ones.
  always_comb begin
    ready_vec   = '0;
    route_ready = 1'b0;
    lock_ready  = 1'b0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      ready_vec[c] = out_miso_i[c].tready;
      if (route  == chan_idx_t'(c)) route_ready = ready_vec[c];
      if (lock_q == chan_idx_t'(c)) lock_ready  = ready_vec[c];
    end
  end

  // Next-state, channel select and input TREADY. Nothing is accepted or
  // presented while reset is held.
  always_comb begin
    state_d  = state_q;
    sel      = lock_q;
    fwd_en   = 1'b0;
    in_ready = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_mosi_i.tvalid) begin
            if (is_header && !unroutable) begin
              sel      = route;
              fwd_en   = 1'b1;
              in_ready = route_ready;
              if (route_ready && !in_mosi_i.data.tlast) state_d = ST_FWD;
            end else begin
              in_ready = 1'b1;
              if (!in_mosi_i.data.tlast) state_d = ST_DROP;
            end
          end
        end
        ST_FWD: begin
          sel      = lock_q;
          fwd_en   = 1'b1;
          in_ready = lock_ready;
          if (in_mosi_i.tvalid && lock_ready && in_mosi_i.data.tlast) state_d = ST_IDLE;
        end
        ST_DROP: begin
          in_ready = 1'b1;
          if (in_mosi_i.tvalid && in_mosi_i.data.tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign hs        = in_mosi_i.tvalid && in_ready;
  assign pkt_done  = hs && in_mosi_i.data.tlast && fwd_en;
  assign drop_done = hs && in_mosi_i.data.tlast && !fwd_en;
  assign in_miso_o.tready = in_ready;

  // Broadcast the data fields; only the selected channel sees TVALID, which
  // depends on input TVALID and state but never on any TREADY.
  always_comb begin
    busy_d = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      out_mosi_o[c].data   = in_mosi_i.data;
      out_mosi_o[c].tvalid = in_mosi_i.tvalid && fwd_en && (sel == chan_idx_t'(c));
      busy_d[c]            = (state_d == ST_FWD) && (sel == chan_idx_t'(c));
    end
  end

  // State, channel lock, busy/drop flags and statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lock_q     <= CH_LOCAL;
      busy_o     <= '0;
      drop_o     <= 1'b0;
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      busy_o  <= busy_d;
      drop_o  <= drop_done;
      if (state_q == ST_IDLE && state_d == ST_FWD) lock_q <= sel;
      if (pkt_done) pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
      if (drop_done && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/route_lock_demux.md
Name: route_lock_demux

Overview:
- Per-input-port routing stage of the AXI-Stream NoC router.
- Steers each packet from one input stream to one of CHANNEL_NUMBER output channels. XY or YX dimension-order routing is chosen by parameter.
- Locks the chosen channel from header to TLAST (wormhole) and drops malformed or unroutable packets.
- Reports per-channel lock state and packet/drop statistics to the router PMU.

Parameters:
- DATA_WIDTH, 32, AXIS TDATA width carried in axis_mosi_t.
- ID_WIDTH, 4, TID width.
- DEST_WIDTH, 4, TDEST width.
- USER_WIDTH, 4, TUSER width.
- CHANNEL_NUMBER, 5, number of output channels: 0 LOCAL, 1 NORTH (y+1), 2 EAST (x+1), 3 SOUTH (y-1), 4 WEST (x-1).
- MAX_ROUTERS_X, 4, mesh width.
- MAX_ROUTERS_Y, 4, mesh height.
- ROUTER_X, 0, this router's X coordinate.
- ROUTER_Y, 0, this router's Y coordinate.
- ROUTING_MODE, 0, 0 = XY (resolve X first), 1 = YX (resolve Y first).
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_mosi_i  in  axis_mosi_t  input stream (TVALID, data.TID/TDATA/TLAST/...).
- in_miso_o  out  axis_miso_t  input TREADY.
- out_mosi_o  out  axis_mosi_t[CHANNEL_NUMBER]  per-channel output streams.
- out_miso_i  in  axis_miso_t[CHANNEL_NUMBER]  per-channel TREADY.
- target_x_i  in  clog2(MAX_ROUTERS_X)  header destination X, decoded upstream; valid with the header beat.
- target_y_i  in  clog2(MAX_ROUTERS_Y)  header destination Y; valid with the header beat.
- busy_o  out  CHANNEL_NUMBER  one-hot: channel currently locked by this input.
- drop_o  out  1  one-cycle pulse on the final (TLAST) handshake of a dropped packet.
- pkt_cnt_o  out  CNT_WIDTH  forwarded packets; wraps.
- drop_cnt_o  out  CNT_WIDTH  dropped packets; saturates at all-ones.

Behaviour:
- Reset (rst_i high, async): state IDLE, lock index 0, busy_o 0, drop_o 0, both counters 0.
- Outputs during and after reset, until a header is seen: every out TVALID 0, in TREADY 0.
- Data fields are broadcast to all channels. Only TVALID is gated, to the selected channel.
- States: IDLE, FWD, DROP.
- Route function (combinational, from target_x_i/target_y_i):
  - XY: dx != ROUTER_X picks EAST or WEST; else dy != ROUTER_Y picks NORTH or SOUTH; else LOCAL.
  - YX: same decision with the axes swapped.
  - Unroutable: target out of mesh range, or the needed channel index >= CHANNEL_NUMBER.
- IDLE, TVALID with TID == ROUTING_HEADER and routable:
  - route = computed channel; out[route].TVALID = 1; in TREADY = out[route].TREADY.
  - On handshake: lock index <= route, busy_o[route] <= 1, next state FWD.
  - If the header beat also has TLAST: stay IDLE, busy stays 0, pkt_cnt += 1.
- IDLE, TVALID with an unroutable header, or with a non-header TID: go to DROP, accepting that beat (TREADY = 1).
  - If that beat has TLAST: drop_o pulses, drop_cnt increments, state stays IDLE.
- FWD:
  - Route is taken from the lock register. target_x_i/target_y_i are ignored.
  - TVALID passes to the locked channel only; TREADY comes from the locked channel only.
  - On TLAST handshake: busy_o cleared next cycle, pkt_cnt += 1, next state IDLE.
  - A header TID seen mid-packet is forwarded as data. No re-route.
- DROP: TREADY = 1, all out TVALID = 0. On TLAST handshake: drop_o = 1 for one cycle, drop_cnt += 1 (saturating), next state IDLE.
- Latency: zero-cycle combinational pass-through. No buffering, no bubbles; one beat per cycle when ready.
- Back-to-back packets: the header of the next packet may handshake in the cycle after TLAST.
- TVALID dropping mid-packet holds state. No timeout.
- Reset mid-packet discards the lock. The upstream/downstream flush is the router's responsibility.
- AXIS rule: TVALID must not depend on TREADY. Output TVALID is derived from input TVALID and state only.

Decomposition:
- Router package (shared):
  - Channel index localparams LOCAL/NORTH/EAST/SOUTH/WEST.
  - ROUTING_HEADER TID value.
  - Routing-mode enum.
  - Typedef for the state enum.
- axis_mosi_t/axis_miso_t come from the existing shared AXIS type include.
- Sub-module route_compute: purely combinational target-to-channel plus unroutable flag, parametrised by mode and coordinates. Reused by the router's ingress checks.

Test Plan:
- 3x3 mesh, ROUTER=(1,1), XY mode:
  - Header target (2,0), 4-beat packet, all ready -> EAST TVALID on 4 consecutive beats; busy_o = 5'b00100 from cycle after header until cycle after TLAST; pkt_cnt = 1.
  - Same packet with ROUTING_MODE = 1 -> SOUTH selected, busy_o = 5'b01000.
  - Header target (1,1) with TLAST on the same beat -> LOCAL single-beat; busy_o stays 0; pkt_cnt += 1.
- Locked channel TREADY low for 3 cycles mid-packet, target inputs changed meanwhile -> in TREADY low, no other channel TVALID, route unchanged.
- Header target (3,0) in a 3-wide mesh, 3 beats; then a data-TID first beat -> each packet is consumed with TREADY = 1, no out TVALID, drop_o pulses once per packet, drop_cnt = 2.
- Assert rst_i mid-FWD -> all out TVALID 0 and busy_o 0 immediately; after release, next header routes normally.
